// File: rtl/load_store_unit.sv
// load_store_unit
//
// Memory-side initiator for a word-only data memory. Accepts load/store requests from the
// datapath, performs byte/halfword loads with sign or zero extension, and implements
// byte/halfword stores as a read-modify-write of the containing word.
//
// Optional build macro: LSU_MISALIGN_TRAP_EN
//   defined   - misaligned LH/LHU/SH (Addr[0]=1) and LW/SW (Addr[1:0]!=0) are aborted with
//               Done=1, Misaligned=1 and no memory access.
//   undefined - Misaligned is tied to 0; offending low address bits are forced to 0 and the
//               access proceeds.
//
// Ports:
//   clk, rst_n   - clock (rising edge), asynchronous active-low reset
//   Req          - request strobe, sampled only when Busy=0
//   Op           - MIPS opcode (LB/LH/LW/LBU/LHU/SB/SH/SW)
//   Addr         - byte address
//   StoreData    - store source (low byte/half for SB/SH)
//   LoadData     - extended load result, held until the next load completes
//   Done         - one-cycle completion pulse
//   Busy         - high while an access is in flight
//   Misaligned   - valid with Done; access was aborted
//   MemAddress   - word-aligned memory address, latched at accept
//   MemDataIn    - write data to memory (0 outside the write cycle)
//   MemRead      - memory read enable
//   MemWrite     - memory write enable
//   MemDataOut   - combinational read data from memory

module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Req,
  input  logic [5:0]            Op,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [31:0]           StoreData,
  output logic [31:0]           LoadData,
  output logic                  Done,
  output logic                  Busy,
  output logic                  Misaligned,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [31:0]           MemDataIn,
  output logic                  MemRead,
  output logic                  MemWrite,
  input  logic [31:0]           MemDataOut
);

  localparam logic [5:0] OpLb  = 6'b100000;
  localparam logic [5:0] OpLh  = 6'b100001;
  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpLbu = 6'b100100;
  localparam logic [5:0] OpLhu = 6'b100101;
  localparam logic [5:0] OpSb  = 6'b101000;
  localparam logic [5:0] OpSh  = 6'b101001;
  localparam logic [5:0] OpSw  = 6'b101011;

  typedef enum logic [1:0] {StIdle, StRead, StRmwRd, StWrite} state_e;

  state_e                state_q;
  logic [5:0]            op_q;
  logic [1:0]            off_q;
  logic [31:0]           sdata_q;
  logic [31:0]           merge_q;
  logic [31:0]           load_data_q;
  logic                  done_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;

  // Request decode (applies to the incoming Op/Addr at accept time)
  logic       req_load, req_sw, req_rmw, req_half, req_word, req_mis;
  logic [1:0] req_off;

  always_comb begin
    req_load = (Op == OpLb) || (Op == OpLh) || (Op == OpLw) || (Op == OpLbu) || (Op == OpLhu);
    req_sw   = (Op == OpSw);
    req_rmw  = (Op == OpSb) || (Op == OpSh);
    req_half = (Op == OpLh) || (Op == OpLhu) || (Op == OpSh);
    req_word = (Op == OpLw) || (Op == OpSw);
`ifdef LSU_MISALIGN_TRAP_EN
    req_mis  = (req_half && Addr[0]) || (req_word && (Addr[1:0] != 2'b00));
`else
    req_mis  = 1'b0;
`endif
    // Lane offset with the illegal low bits cleared; aligned requests are unaffected.
    if (req_word) begin
      req_off = 2'b00;
    end else if (req_half) begin
      req_off = {Addr[1], 1'b0};
    end else begin
      req_off = Addr[1:0];
    end
  end

  // Lane selection on the latched offset. In big-endian order byte k sits at bits
  // [31-8k -: 8], so the shift for byte k is 8*(3-k) = {~k, 3'b000}.
  logic [4:0]  byte_sh, half_sh;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ext_data;
  logic [31:0] lane_mask, lane_ins, merge_val;

  always_comb begin
    if (BIG_ENDIAN) begin
      byte_sh = {~off_q, 3'b000};
      half_sh = {~off_q[1], 4'b0000};
    end else begin
      byte_sh = {off_q, 3'b000};
      half_sh = {off_q[1], 4'b0000};
    end
    rd_byte = 8'(MemDataOut >> byte_sh);
    rd_half = 16'(MemDataOut >> half_sh);

    case (op_q)
      OpLb:    ext_data = {{24{rd_byte[7]}}, rd_byte};
      OpLbu:   ext_data = {24'b0, rd_byte};
      OpLh:    ext_data = {{16{rd_half[15]}}, rd_half};
      OpLhu:   ext_data = {16'b0, rd_half};
      default: ext_data = MemDataOut;
    endcase

    if (op_q == OpSb) begin
      lane_mask = 32'h0000_00FF << byte_sh;
      lane_ins  = {24'b0, sdata_q[7:0]} << byte_sh;
    end else begin
      lane_mask = 32'h0000_FFFF << half_sh;
      lane_ins  = {16'b0, sdata_q[15:0]} << half_sh;
    end
    merge_val = (MemDataOut & ~lane_mask) | lane_ins;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= '0;
      off_q       <= '0;
      sdata_q     <= '0;
      merge_q     <= '0;
      load_data_q <= '0;
      done_q      <= 1'b0;
      mem_addr_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q  <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (Req) begin
            op_q       <= Op;
            off_q      <= req_off;
            sdata_q    <= StoreData;
            mem_addr_q <= {Addr[ADDR_WIDTH-1:2], 2'b00};
            if (req_mis) begin
              done_q <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
              mis_q  <= 1'b1;
`endif
            end else if (req_load) begin
              state_q <= StRead;
            end else if (req_sw) begin
              state_q <= StWrite;
            end else if (req_rmw) begin
              state_q <= StRmwRd;
            end else begin
              // Unsupported opcode: complete immediately without touching memory.
              done_q <= 1'b1;
            end
          end
        end
        StRead: begin
          load_data_q <= ext_data;
          done_q      <= 1'b1;
          state_q     <= StIdle;
        end
        StRmwRd: begin
          merge_q <= merge_val;
          state_q <= StWrite;
        end
        StWrite: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign Misaligned = mis_q;
`else
  assign Misaligned = 1'b0;
`endif

  // Memory strobes decode straight from state so an asynchronous reset drops them at once.
  assign MemRead    = (state_q == StRead) || (state_q == StRmwRd);
  assign MemWrite   = (state_q == StWrite);
  assign MemDataIn  = (state_q != StWrite) ? 32'h0 : ((op_q == OpSw) ? sdata_q : merge_q);
  assign Busy       = (state_q != StIdle);
  assign Done       = done_q;
  assign LoadData   = load_data_q;
  assign MemAddress = mem_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam logic [5:0] OpLb  = 6'b100000;
  localparam logic [5:0] OpLh  = 6'b100001;
  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpLbu = 6'b100100;
  localparam logic [5:0] OpLhu = 6'b100101;
  localparam logic [5:0] OpSb  = 6'b101000;
  localparam logic [5:0] OpSh  = 6'b101001;
  localparam logic [5:0] OpSw  = 6'b101011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Req = 1'b0;
  logic [5:0]  Op = '0;
  logic [31:0] Addr = '0;
  logic [31:0] StoreData = '0;
  logic [31:0] LoadData;
  logic        Done, Busy, Misaligned;
  logic [31:0] MemAddress, MemDataIn, MemDataOut;
  logic        MemRead, MemWrite;

  load_store_unit #(
    .ADDR_WIDTH(32),
    .BIG_ENDIAN(1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Req       (Req),
    .Op        (Op),
    .Addr      (Addr),
    .StoreData (StoreData),
    .LoadData  (LoadData),
    .Done      (Done),
    .Busy      (Busy),
    .Misaligned(Misaligned),
    .MemAddress(MemAddress),
    .MemDataIn (MemDataIn),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .MemDataOut(MemDataOut)
  );

  always #5 clk = ~clk;

  // Word-only memory model
  logic [31:0] mem [16];
  logic        mem_load = 1'b1;
  assign MemDataOut = MemRead ? mem[MemAddress[5:2]] : 32'h0;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h8899AABB;
      mem[1] <= 32'h11223344;
    end else if (MemWrite) begin
      mem[MemAddress[5:2]] <= MemDataIn;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] ld;
    logic        mis;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] wdata;
    logic [31:0] maddr;
    int          issue;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  logic wr_seen = 1'b0;
  logic [31:0] exp_ld = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] ld, input logic mis, input int lat,
                              input int rd, input int wr, input logic [31:0] wdata,
                              input logic [31:0] maddr);
    exp_t e;
    e.ld = ld; e.mis = mis; e.lat = lat; e.rd = rd; e.wr = wr;
    e.wdata = wdata; e.maddr = maddr; e.issue = 0;
    return e;
  endfunction

  // Monitor: checks bus activity against the oldest outstanding request, pops on Done.
  always @(negedge clk) begin
    if (MemWrite) wr_seen = 1'b1;
    if (rst_n) begin
      check("busy_vs_strobes", {31'b0, Busy}, {31'b0, MemRead | MemWrite});
      if (MemRead || MemWrite) begin
        if (MemRead) rd_cnt++;
        if (MemWrite) begin
          wr_cnt++;
          if (sb_q.size() > 0) check("mem_wdata", MemDataIn, sb_q[0].wdata);
        end
        if (sb_q.size() > 0) check("mem_addr", MemAddress, sb_q[0].maddr);
      end else begin
        check("wdata_idle_zero", MemDataIn, 32'h0);
      end
      if (Done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("load_data", LoadData, e.ld);
          check("misaligned", {31'b0, Misaligned}, {31'b0, e.mis});
          check("latency", 32'(cyc - e.issue), 32'(e.lat));
          check("read_cycles", 32'(rd_cnt), 32'(e.rd));
          check("write_cycles", 32'(wr_cnt), 32'(e.wr));
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end else begin
      rd_cnt = 0;
      wr_cnt = 0;
    end
  end

  // Waits for Busy=0, then presents the request for exactly one clock edge.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input exp_t e);
    int n;
    n = 0;
    while (Busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (Busy) check("issue_timeout", 32'h1, 32'h0);
    e.issue = cyc;
    sb_q.push_back(e);
    Req = 1'b1; Op = op; Addr = a; StoreData = sd;
    @(posedge clk); #1;
    Req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() > 0) begin
      check("drain_timeout", 32'(sb_q.size()), 32'h0);
      sb_q.delete();
    end
  endtask

  task automatic load(input logic [5:0] op, input logic [31:0] a, input logic [31:0] ld);
    exp_ld = ld;
    issue(op, a, 32'h0, mk(ld, 1'b0, 2, 1, 0, 32'h0, {a[31:2], 2'b00}));
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_loaddata", LoadData, 32'h0);
    check("rst_done", {31'b0, Done}, 32'h0);
    check("rst_busy", {31'b0, Busy}, 32'h0);
    check("rst_misaligned", {31'b0, Misaligned}, 32'h0);
    check("rst_memaddr", MemAddress, 32'h0);
    check("rst_strobes", {30'b0, MemRead, MemWrite}, 32'h0);
    mem_load = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Loads, including back-to-back issue in the Done cycle
    load(OpLb, 32'h1, 32'hFFFFFF99);
    load(OpLbu, 32'h3, 32'h000000BB);
    load(OpLhu, 32'h0, 32'h00008899);

    // SB read-modify-write, then verify with LW
    issue(OpSb, 32'h2, 32'h12345677, mk(exp_ld, 1'b0, 3, 1, 1, 32'h889977BB, 32'h0));
    load(OpLw, 32'h0, 32'h889977BB);

    // SH then SW
    issue(OpSh, 32'h2, 32'h0000CAFE, mk(exp_ld, 1'b0, 3, 1, 1, 32'h8899CAFE, 32'h0));
    issue(OpSw, 32'h4, 32'hDEADBEEF, mk(exp_ld, 1'b0, 2, 0, 1, 32'hDEADBEEF, 32'h4));
    load(OpLw, 32'h4, 32'hDEADBEEF);
    load(OpLw, 32'h0, 32'h8899CAFE);
    load(OpLh, 32'h2, 32'hFFFFCAFE);
    load(OpLb, 32'h0, 32'hFFFFFF88);

    // Misaligned halfword load and word store
`ifdef LSU_MISALIGN_TRAP_EN
    issue(OpLh, 32'h1, 32'h0, mk(exp_ld, 1'b1, 1, 0, 0, 32'h0, 32'h0));
    issue(OpSw, 32'h6, 32'h01020304, mk(exp_ld, 1'b1, 1, 0, 0, 32'h0, 32'h4));
    load(OpLw, 32'h4, 32'hDEADBEEF);
`else
    load(OpLh, 32'h1, 32'hFFFF8899);
    issue(OpSw, 32'h6, 32'h01020304, mk(exp_ld, 1'b0, 2, 0, 1, 32'h01020304, 32'h4));
    load(OpLw, 32'h4, 32'h01020304);
`endif

    // Unsupported opcode completes at once with no access
    issue(6'b000000, 32'h0, 32'h0, mk(exp_ld, 1'b0, 1, 0, 0, 32'h0, 32'h0));
    drain();

    // Reset in the middle of an SB read-modify-write
    Req = 1'b1; Op = OpSb; Addr = 32'h0; StoreData = 32'h00000055;
    @(posedge clk); #1;
    Req = 1'b0;
    check("rmw_memread", {31'b0, MemRead}, 32'h1);
    wr_seen = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_memread", {31'b0, MemRead}, 32'h0);
    check("abort_memwrite", {31'b0, MemWrite}, 32'h0);
    check("abort_busy", {31'b0, Busy}, 32'h0);
    check("abort_done", {31'b0, Done}, 32'h0);
    check("abort_loaddata", LoadData, 32'h0);
    check("abort_memaddr", MemAddress, 32'h0);
    check("abort_wdata", MemDataIn, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_write", {31'b0, wr_seen}, 32'h0);
    check("abort_word_kept", mem[0], 32'h8899CAFE);
    load(OpLw, 32'h0, 32'h8899CAFE);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
